reg_decode_stage_v2: RTL and testbench

Parametrised decode/register-read stage feeding the execute stage. It contains a REG_NUM x REG_WIDTH register file with write-first bypass and selectable read and write-address sources. It performs runtime sign- or zero-extension of the immediate and drives a valid-qualified pipeline register. Load-use hazard detection, stall and flush handling are built in; the register file is the sub-module regfile_bypass.

---
 rtl/reg_decode_pkg.sv | 15 +
 rtl/reg_decode_stage_v2_regfile.sv | 27 ++
 rtl/reg_decode_stage_v2.sv | 113 +++++++++++
 tb/tb_reg_decode_stage_v2.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_decode_pkg.sv
// reg_decode_pkg: shared control-bundle layout and destination-select codes
package reg_decode_pkg;
  localparam int CTRL_W = 11;
  localparam int ALU_IN2_SEL = 10;
  localparam int ALU_CTRL_HI = 9;
  localparam int ALU_CTRL_LO = 5;
  localparam int BRANCH = 4;
  localparam int MEM_WR_EN = 3;
  localparam int MEM2REG = 2;
  localparam int REG_WR_EN = 1;
  localparam int MEM_ADDR_SEL = 0;
  localparam logic [1:0] FWD_SEL_ADDR1 = 2'b00;
  localparam logic [1:0] FWD_SEL_ADDR2 = 2'b01;
  localparam logic [1:0] FWD_SEL_CU = 2'b10;
endpackage

// File: rtl/reg_decode_stage_v2_regfile.sv
// regfile_bypass: 2R1W register file, async clear, write-first read bypass
module regfile_bypass #(
  parameter int REG_WIDTH = 16,
  parameter int REG_NUM = 16,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [REG_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]    rd1_addr_i,
  input  logic [ADDR_W-1:0]    rd2_addr_i,
  output logic [REG_WIDTH-1:0] rd1_data_o,
  output logic [REG_WIDTH-1:0] rd2_data_o
);
  logic [REG_WIDTH-1:0] mem_q [REG_NUM];
  // storage: cleared by reset, writes to the hardwired zero register dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem_q <= '{default: '0};
    else if (wr_en_i && !(ZERO_REG && wr_addr_i == '0)) mem_q[wr_addr_i] <= wr_data_i;
  assign rd1_data_o = (ZERO_REG && rd1_addr_i == '0) ? '0 :
                      (wr_en_i && wr_addr_i == rd1_addr_i) ? wr_data_i : mem_q[rd1_addr_i];
  assign rd2_data_o = (ZERO_REG && rd2_addr_i == '0) ? '0 :
                      (wr_en_i && wr_addr_i == rd2_addr_i) ? wr_data_i : mem_q[rd2_addr_i];
endmodule

// File: rtl/reg_decode_stage_v2.sv
// reg_decode_stage_v2: decode/register-read stage with hazard, stall and flush control
module reg_decode_stage_v2 import reg_decode_pkg::*; #(
  parameter int REG_WIDTH = 16,
  parameter int REG_NUM = 16,
  parameter int IMM_WIDTH = 11,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_1_valid,
  input  logic                 i_1_stall,
  input  logic                 i_1_flush,
  input  logic [CTRL_W-1:0]    i_11_ctrl,
  input  logic                 i_1_rd1_addr_sel,
  input  logic                 i_1_rd2_addr_sel,
  input  logic [1:0]           i_2_fwd_wr_sel,
  input  logic [ADDR_W-1:0]    i_A_rd1_addr_cu,
  input  logic [ADDR_W-1:0]    i_A_rd1_addr1,
  input  logic [ADDR_W-1:0]    i_A_rd2_addr1,
  input  logic [ADDR_W-1:0]    i_A_rd2_addr2,
  input  logic [ADDR_W-1:0]    i_A_fwd_wr_addr_cu,
  input  logic [ADDR_W-1:0]    i_A_fwd_wr_addr1,
  input  logic [ADDR_W-1:0]    i_A_fwd_wr_addr2,
  input  logic                 i_1_imm_sext,
  input  logic [IMM_WIDTH-1:0] i_I_imm,
  input  logic [REG_WIDTH-1:0] i_R_pcplus,
  input  logic                 i_1_wr_en,
  input  logic [ADDR_W-1:0]    i_A_wr_addr,
  input  logic [REG_WIDTH-1:0] i_R_wr_data,
  output logic                 o_1_ready,
  output logic                 o_1_hazard,
  output logic                 or_1_valid,
  output logic [CTRL_W-1:0]    or_11_ctrl,
  output logic [REG_WIDTH-1:0] or_R_rd1_data,
  output logic [REG_WIDTH-1:0] or_R_rd2_data,
  output logic [ADDR_W-1:0]    or_A_reg_wr_addr,
  output logic [REG_WIDTH-1:0] or_R_imm,
  output logic [REG_WIDTH-1:0] or_R_pcplus
);
  if (IMM_WIDTH > REG_WIDTH) begin : g_bad_imm
    $error("IMM_WIDTH must not exceed REG_WIDTH");
  end
  logic [ADDR_W-1:0] rd1_addr, rd2_addr, dst_addr, wa_q, wa_d;
  logic [REG_WIDTH-1:0] rd1_data, rd2_data, imm_ext;
  logic [REG_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic valid_q, valid_d;
  assign rd1_addr = i_1_rd1_addr_sel ? i_A_rd1_addr_cu : i_A_rd1_addr1;
  assign rd2_addr = i_1_rd2_addr_sel ? i_A_rd2_addr1 : i_A_rd2_addr2;
  assign dst_addr = i_2_fwd_wr_sel == FWD_SEL_ADDR2 ? i_A_fwd_wr_addr2 :
                    i_2_fwd_wr_sel == FWD_SEL_CU ? i_A_fwd_wr_addr_cu : i_A_fwd_wr_addr1;
  assign o_1_hazard = i_1_valid & valid_q & ctrl_q[MEM2REG] & ctrl_q[REG_WR_EN] &
                      ((wa_q == rd1_addr) | (wa_q == rd2_addr)) & ~(ZERO_REG & (wa_q == '0));
  assign o_1_ready = ~i_1_stall & ~o_1_hazard;
  regfile_bypass #(.REG_WIDTH(REG_WIDTH), .REG_NUM(REG_NUM), .ZERO_REG(ZERO_REG)) u_rf (
    .clk(clk), .rst(rst), .wr_en_i(i_1_wr_en), .wr_addr_i(i_A_wr_addr), .wr_data_i(i_R_wr_data),
    .rd1_addr_i(rd1_addr), .rd2_addr_i(rd2_addr), .rd1_data_o(rd1_data), .rd2_data_o(rd2_data)
  );
  // immediate extension: fill with the raw MSB when sign-extending, else zeros
  always_comb begin
    imm_ext = {REG_WIDTH{i_1_imm_sext & i_I_imm[IMM_WIDTH-1]}};
    imm_ext[IMM_WIDTH-1:0] = i_I_imm;
  end
  // stage-register next state: flush beats stall, stall holds, hazard/invalid bubbles
  always_comb begin
    valid_d = valid_q;
    ctrl_d = ctrl_q;
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    wa_d = wa_q;
    imm_d = imm_q;
    pc_d = pc_q;
    if (i_1_flush) begin
      valid_d = 1'b0;
      ctrl_d = '0;
    end else if (!i_1_stall) begin
      valid_d = i_1_valid & ~o_1_hazard;
      ctrl_d = valid_d ? i_11_ctrl : '0;
      rd1_d = rd1_data;
      rd2_d = rd2_data;
      wa_d = dst_addr;
      imm_d = imm_ext;
      pc_d = i_R_pcplus;
    end
  end
  // stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      wa_q <= '0;
      imm_q <= '0;
      pc_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q <= ctrl_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      wa_q <= wa_d;
      imm_q <= imm_d;
      pc_q <= pc_d;
    end
  assign or_1_valid = valid_q;
  assign or_11_ctrl = ctrl_q;
  assign or_R_rd1_data = rd1_q;
  assign or_R_rd2_data = rd2_q;
  assign or_A_reg_wr_addr = wa_q;
  assign or_R_imm = imm_q;
  assign or_R_pcplus = pc_q;
endmodule

// File: tb/tb_reg_decode_stage_v2.sv
// tb_reg_decode_stage_v2: directed and random checks of two stage copies (ZERO_REG 0 and 1)
module tb_reg_decode_stage_v2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic valid, stall, flush, s1, s2, sext, wen;
  logic [10:0] ctrl, imm;
  logic [1:0] fsel;
  logic [3:0] a1cu, a1a1, a2a1, a2a2, wcu, wa1, wa2, waddr;
  logic [15:0] pc, wdata;
  logic [1:0] rdy, hz, ov;
  logic [1:0][10:0] oc;
  logic [1:0][15:0] o1, o2, oi, op;
  logic [1:0][3:0] owa;
  int tests = 0;
  int fails = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    reg_decode_stage_v2 #(.ZERO_REG(g == 1)) dut (
      .clk(clk), .rst(rst), .i_1_valid(valid), .i_1_stall(stall), .i_1_flush(flush),
      .i_11_ctrl(ctrl), .i_1_rd1_addr_sel(s1), .i_1_rd2_addr_sel(s2), .i_2_fwd_wr_sel(fsel),
      .i_A_rd1_addr_cu(a1cu), .i_A_rd1_addr1(a1a1), .i_A_rd2_addr1(a2a1), .i_A_rd2_addr2(a2a2),
      .i_A_fwd_wr_addr_cu(wcu), .i_A_fwd_wr_addr1(wa1), .i_A_fwd_wr_addr2(wa2),
      .i_1_imm_sext(sext), .i_I_imm(imm), .i_R_pcplus(pc),
      .i_1_wr_en(wen), .i_A_wr_addr(waddr), .i_R_wr_data(wdata),
      .o_1_ready(rdy[g]), .o_1_hazard(hz[g]), .or_1_valid(ov[g]), .or_11_ctrl(oc[g]),
      .or_R_rd1_data(o1[g]), .or_R_rd2_data(o2[g]), .or_A_reg_wr_addr(owa[g]),
      .or_R_imm(oi[g]), .or_R_pcplus(op[g])
    );
  end
  typedef struct packed {
    logic v; logic [10:0] c; logic [15:0] r1, r2; logic [3:0] wa; logic [15:0] imm, pc;
  } st_t;
  st_t ex [2];
  logic [15:0] rf [2][16];
  function automatic logic [79:0] obs(int z);
    return {ov[z], oc[z], o1[z], o2[z], owa[z], oi[z], op[z]};
  endfunction
  function automatic logic [3:0] ra1();
    return s1 ? a1cu : a1a1;
  endfunction
  function automatic logic [3:0] ra2();
    return s2 ? a2a1 : a2a2;
  endfunction
  function automatic logic [15:0] rd(int z, logic [3:0] a);
    if (z == 1 && a == 0) return 16'h0;
    if (wen && waddr == a) return wdata;
    return rf[z][a];
  endfunction
  function automatic logic haz(int z);
    return valid && ex[z].v && ex[z].c[2] && ex[z].c[1] &&
           (ex[z].wa == ra1() || ex[z].wa == ra2()) && !(z == 1 && ex[z].wa == 0);
  endfunction
  task automatic model_clear();
    for (int z = 0; z < 2; z++) begin
      ex[z] = '0;
      for (int a = 0; a < 16; a++) rf[z][a] = 16'h0;
    end
  endtask
  task automatic idle();
    {valid, stall, flush, s1, s2, sext, wen} = '0;
    {ctrl, imm, fsel, a1cu, a1a1, a2a1, a2a2, wcu, wa1, wa2, waddr, pc, wdata} = '0;
  endtask
  task automatic tick();
    st_t n [2];
    for (int z = 0; z < 2; z++) begin
      n[z] = ex[z];
      if (flush) begin
        n[z].v = 1'b0;
        n[z].c = '0;
      end else if (!stall) begin
        n[z].v = valid && !haz(z);
        n[z].c = n[z].v ? ctrl : 11'h0;
        n[z].r1 = rd(z, ra1());
        n[z].r2 = rd(z, ra2());
        n[z].wa = fsel == 2'b01 ? wa2 : fsel == 2'b10 ? wcu : wa1;
        n[z].imm = sext ? 16'($signed(imm)) : 16'(imm);
        n[z].pc = pc;
      end
    end
    @(posedge clk);
    for (int z = 0; z < 2; z++) begin
      ex[z] = n[z];
      if (wen && !(z == 1 && waddr == 0)) rf[z][waddr] = wdata;
    end
    #1;
  endtask
  task automatic test_reset();
    idle();
    model_clear();
    #2;
    for (int z = 0; z < 2; z++) begin
      tests++;
      if (obs(z) !== 80'h0) begin
        $display("FAIL reset_state dut%0d got %h exp 0", z, obs(z));
        fails++;
      end
    end
    rst = 1'b1;
    tick();
    for (int z = 0; z < 2; z++) begin
      tests++;
      if (obs(z) !== ex[z]) begin
        $display("FAIL reset_release dut%0d got %h exp %h", z, obs(z), ex[z]);
        fails++;
      end
    end
  endtask
  task automatic test_async_reset();
    idle();
    wen = 1'b1; waddr = 4'd5; wdata = 16'h1234;
    valid = 1'b1; ctrl = 11'h7FF; pc = 16'hBEEF; imm = 11'h3FF; wa1 = 4'd9;
    tick();
    wen = 1'b0; s1 = 1'b0; a1a1 = 4'd5;
    tick();
    tests++;
    if (o1[0] !== 16'h1234 || ov[0] !== 1'b1) begin
      $display("FAIL pre_reset_read got %h/%b exp 1234/1", o1[0], ov[0]);
      fails++;
    end
    #3 rst = 1'b0;
    model_clear();
    #1;
    for (int z = 0; z < 2; z++) begin
      tests++;
      if (obs(z) !== 80'h0) begin
        $display("FAIL async_reset dut%0d got %h exp 0", z, obs(z));
        fails++;
      end
    end
    #2 rst = 1'b1;
    idle();
    valid = 1'b1; a1a1 = 4'd5;
    tick();
    tests++;
    if (o1[0] !== 16'h0 || obs(0) !== ex[0]) begin
      $display("FAIL reset_cleared_r5 got %h exp %h", obs(0), ex[0]);
      fails++;
    end
  endtask
  task automatic test_bypass();
    idle();
    wen = 1'b1; waddr = 4'd7; wdata = 16'hA5A5;
    valid = 1'b1; s1 = 1'b1; a1cu = 4'd7; a1a1 = 4'd2;
    tick();
    for (int z = 0; z < 2; z++) begin
      tests++;
      if (o1[z] !== 16'hA5A5 || obs(z) !== ex[z]) begin
        $display("FAIL write_first_bypass dut%0d got %h exp rd1=a5a5 %h", z, obs(z), ex[z]);
        fails++;
      end
    end
  endtask
  task automatic test_hazard();
    idle();
    valid = 1'b1; ctrl = 11'h006; wa1 = 4'd3;
    tick();
    ctrl = 11'h000; wa1 = 4'd8; a1a1 = 4'd9; s2 = 1'b0; a2a2 = 4'd3;
    #1;
    for (int z = 0; z < 2; z++) begin
      tests++;
      if (hz[z] !== 1'b1 || rdy[z] !== 1'b0) begin
        $display("FAIL load_use_detect dut%0d got hz=%b rdy=%b exp 1/0", z, hz[z], rdy[z]);
        fails++;
      end
    end
    tick();
    tests++;
    if (ov[0] !== 1'b0 || oc[0] !== 11'h0 || obs(0) !== ex[0]) begin
      $display("FAIL hazard_bubble got v=%b c=%h exp 0/0", ov[0], oc[0]);
      fails++;
    end
    tests++;
    if (hz[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      $display("FAIL hazard_clear got hz=%b rdy=%b exp 0/1", hz[0], rdy[0]);
      fails++;
    end
    tick();
    tests++;
    if (ov[0] !== 1'b1 || owa[0] !== 4'd8 || obs(0) !== ex[0]) begin
      $display("FAIL hazard_issue got v=%b wa=%h exp 1/8", ov[0], owa[0]);
      fails++;
    end
  endtask
  task automatic test_imm();
    idle();
    valid = 1'b1; imm = 11'h400; sext = 1'b1;
    tick();
    tests++;
    if (oi[0] !== 16'hFC00) begin
      $display("FAIL imm_sext got %h exp fc00", oi[0]);
      fails++;
    end
    sext = 1'b0;
    tick();
    tests++;
    if (oi[0] !== 16'h0400) begin
      $display("FAIL imm_zext got %h exp 0400", oi[0]);
      fails++;
    end
    imm = 11'h3AB; sext = 1'b1;
    tick();
    tests++;
    if (oi[0] !== 16'h03AB) begin
      $display("FAIL imm_sext_pos got %h exp 03ab", oi[0]);
      fails++;
    end
  endtask
  task automatic test_stall_flush();
    st_t snap;
    idle();
    valid = 1'b1; ctrl = 11'h5A1; pc = 16'h0042; wa1 = 4'd6; imm = 11'h123;
    tick();
    snap = ex[0];
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctrl = 11'($urandom); pc = 16'($urandom); imm = 11'($urandom); wa1 = 4'($urandom);
      tick();
      tests++;
      if (obs(0) !== snap || obs(0) !== ex[0]) begin
        $display("FAIL stall_hold cyc%0d got %h exp %h", i, obs(0), snap);
        fails++;
      end
    end
    flush = 1'b1;
    tick();
    tests++;
    if (ov[0] !== 1'b0 || oc[0] !== 11'h0) begin
      $display("FAIL flush_over_stall got v=%b c=%h exp 0/0", ov[0], oc[0]);
      fails++;
    end
  endtask
  task automatic test_zero_reg();
    idle();
    wen = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; valid = 1'b1;
    tick();
    tests++;
    if (o1[1] !== 16'h0 || o1[0] !== 16'hFFFF) begin
      $display("FAIL zero_reg_bypass got z1=%h z0=%h exp 0/ffff", o1[1], o1[0]);
      fails++;
    end
    wen = 1'b0;
    tick();
    tests++;
    if (o1[1] !== 16'h0 || o1[0] !== 16'hFFFF) begin
      $display("FAIL zero_reg_read got z1=%h z0=%h exp 0/ffff", o1[1], o1[0]);
      fails++;
    end
    fsel = 2'b11; wa1 = 4'd4; wa2 = 4'd9; wcu = 4'd12;
    tick();
    tests++;
    if (owa[1] !== 4'd4 || owa[0] !== 4'd4) begin
      $display("FAIL fwd_sel_11 got %h/%h exp 4", owa[1], owa[0]);
      fails++;
    end
    fsel = 2'b00; wa1 = 4'd0; ctrl = 11'h006;
    tick();
    ctrl = 11'h0; a1a1 = 4'd5; s2 = 1'b0; a2a2 = 4'd0;
    #1;
    tests++;
    if (hz[0] !== 1'b1 || hz[1] !== 1'b0) begin
      $display("FAIL zero_reg_hazard_mask got z0=%b z1=%b exp 1/0", hz[0], hz[1]);
      fails++;
    end
    tick();
  endtask
  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      valid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 11) == 0;
      ctrl = 11'($urandom);
      if ($urandom_range(0, 1) == 1) ctrl[2:1] = 2'b11;
      s1 = 1'($urandom); s2 = 1'($urandom); fsel = 2'($urandom); sext = 1'($urandom);
      a1cu = 4'($urandom_range(0, 3)); a1a1 = 4'($urandom_range(0, 3));
      a2a1 = 4'($urandom_range(0, 3)); a2a2 = 4'($urandom_range(0, 3));
      wcu = 4'($urandom_range(0, 3)); wa1 = 4'($urandom_range(0, 3)); wa2 = 4'($urandom_range(0, 3));
      imm = 11'($urandom); pc = 16'($urandom);
      wen = 1'($urandom); waddr = 4'($urandom_range(0, 5)); wdata = 16'($urandom);
      #1;
      for (int z = 0; z < 2; z++) begin
        tests++;
        if (hz[z] !== haz(z) || rdy[z] !== (!stall && !haz(z))) begin
          $display("FAIL rand_comb dut%0d cyc%0d got hz=%b rdy=%b exp %b/%b", z, i, hz[z], rdy[z],
                   haz(z), !stall && !haz(z));
          fails++;
        end
      end
      tick();
      for (int z = 0; z < 2; z++) begin
        tests++;
        if (obs(z) !== ex[z]) begin
          $display("FAIL rand_stage dut%0d cyc%0d got %h exp %h", z, i, obs(z), ex[z]);
          fails++;
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_async_reset();
    test_bypass();
    test_hazard();
    test_imm();
    test_stall_flush();
    test_zero_reg();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
